// File: rtl/nes_controller.sv
// Dual NES controller port: per-bit synchronize and debounce of raw buttons,
// then a latch/shift serializer per player emulating the 4021 shift register.
module nes_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] btn_p1,
    input  logic [7:0] btn_p2,
    input  logic       ctlr_latch,
    input  logic       ctlr_pulse_p1,
    input  logic       ctlr_pulse_p2,
    output logic       ctlr_data_p1,
    output logic       ctlr_data_p2,
    output logic [7:0] btn_db_p1,
    output logic [7:0] btn_db_p2
);

    localparam logic [15:0] CNT_TC = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] raw;
    logic [15:0] sync1_q, sync1_d;
    logic [15:0] sync2_q, sync2_d;
    logic [15:0] db_q, db_d;
    logic [15:0] cnt_q [16];
    logic [15:0] cnt_d [16];
    logic [1:0]  pulse;
    logic [1:0]  pulse_q, pulse_d;
    logic [1:0]  rise;
    logic [7:0]  sr_q [2];
    logic [7:0]  sr_d [2];

    assign raw   = {btn_p2, btn_p1};
    assign pulse = {ctlr_pulse_p2, ctlr_pulse_p1};
    assign rise  = pulse & ~pulse_q;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        pulse_d = pulse;
        for (int i = 0; i < 16; i++) begin
            cnt_d[i] = 16'd0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
        // Latch has priority over a coincident pulse edge; bit7 fills with 1s
        // so reads past the eighth return "pressed" like an official pad.
        for (int p = 0; p < 2; p++) begin
            sr_d[p] = sr_q[p];
            if (ctlr_latch) begin
                sr_d[p] = db_q[p*8 +: 8];
            end else if (rise[p]) begin
                sr_d[p] = {1'b1, sr_q[p][7:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 16'd0;
            sync2_q <= 16'd0;
            db_q    <= 16'd0;
            pulse_q <= 2'b00;
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= 16'd0;
            end
            for (int p = 0; p < 2; p++) begin
                sr_q[p] <= 8'd0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            for (int p = 0; p < 2; p++) begin
                sr_q[p] <= sr_d[p];
            end
        end
    end

    assign ctlr_data_p1 = ~sr_q[0][0];
    assign ctlr_data_p2 = ~sr_q[1][0];
    assign btn_db_p1    = db_q[7:0];
    assign btn_db_p2    = db_q[15:8];

endmodule
